sram_march_bist: RTL and testbench

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

---
 rtl/sram_march_bist.sv | 194 +++++++++++++++++++
 tb/tb_sram_march_bist.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_march_bist.sv
// March C- memory BIST controller: drives an SRAM BIST port one operation per cycle
// and compares read data against the expected background one cycle after each read.
module sram_march_bist #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic              A_BIST_CLK,
  input  logic              A_BIST_RST,
  input  logic              START,
  input  logic [DATA_W-1:0] A_DOUT,
  output logic              A_BIST_EN,
  output logic              A_BIST_MEN,
  output logic              A_BIST_WEN,
  output logic              A_BIST_REN,
  output logic [ADDR_W-1:0] A_BIST_ADDR,
  output logic [DATA_W-1:0] A_BIST_DIN,
  output logic [DATA_W-1:0] A_BIST_BM,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAIL,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [7:0]        FAIL_CNT
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [DATA_W-1:0] ONES     = '1;
  localparam logic [7:0]        CNT_MAX  = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE, ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5, ST_FLUSH, ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic                en_q, en_d, men_q, men_d, wen_q, wen_d, ren_q, ren_d;
  logic [DATA_W-1:0]   din_q, din_d, bm_q, bm_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [7:0]          fail_cnt_q, fail_cnt_d;
  logic                accept;
  logic                mismatch;

  always_ff @(posedge A_BIST_CLK or posedge A_BIST_RST) begin
    if (A_BIST_RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      en_q        <= 1'b0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      din_q       <= '0;
      bm_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmp_vld_q   <= 1'b0;
      exp_q       <= '0;
      raddr_q     <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      en_q        <= en_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      din_q       <= din_d;
      bm_q        <= bm_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmp_vld_q   <= cmp_vld_d;
      exp_q       <= exp_d;
      raddr_q     <= raddr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  // Sequencer; wr_q selects the write half of two-operation elements.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    accept  = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_M0;
          addr_d  = '0;
          wr_d    = 1'b0;
        end
      end
      ST_M0: begin
        if (addr_q == ADDR_MAX) begin
          state_d = ST_M1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_M1, ST_M2: begin
        wr_d = ~wr_q;
        if (wr_q) begin
          if (addr_q == ADDR_MAX) begin
            state_d = (state_q == ST_M1) ? ST_M2 : ST_M3;
            addr_d  = (state_q == ST_M1) ? '0 : ADDR_MAX;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_M3, ST_M4: begin
        wr_d = ~wr_q;
        if (wr_q) begin
          if (addr_q == '0) begin
            state_d = (state_q == ST_M3) ? ST_M4 : ST_M5;
            addr_d  = (state_q == ST_M3) ? ADDR_MAX : '0;
          end else begin
            addr_d = addr_q - ADDR_W'(1);
          end
        end
      end
      ST_M5: begin
        if (addr_q == ADDR_MAX) begin
          state_d = ST_FLUSH;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        wr_d    = 1'b0;
      end
    endcase

    // Port controls are decoded from the next state so they line up with state_q.
    en_d   = state_d inside {ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5, ST_FLUSH};
    men_d  = state_d inside {ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5};
    wen_d  = (state_d == ST_M0) ||
             ((state_d inside {ST_M1, ST_M2, ST_M3, ST_M4}) && wr_d);
    ren_d  = (state_d == ST_M5) ||
             ((state_d inside {ST_M1, ST_M2, ST_M3, ST_M4}) && !wr_d);
    din_d  = (wen_d && ((state_d == ST_M1) || (state_d == ST_M3))) ? ONES : '0;
    bm_d   = en_d ? ONES : '0;
    busy_d = en_d;
    done_d = (state_d == ST_DONE);
  end

  // Read checking: capture expectation in the read cycle, compare data one cycle later.
  always_comb begin
    cmp_vld_d   = ren_q;
    exp_d       = ((state_q == ST_M2) || (state_q == ST_M4)) ? ONES : '0;
    raddr_d     = addr_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_cnt_d  = fail_cnt_q;
    mismatch    = cmp_vld_q && (A_DOUT != exp_q);
    if (accept) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_cnt_d  = '0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = raddr_q;
      if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 8'(1);
    end
  end

  assign A_BIST_EN   = en_q;
  assign A_BIST_MEN  = men_q;
  assign A_BIST_WEN  = wen_q;
  assign A_BIST_REN  = ren_q;
  assign A_BIST_ADDR = addr_q;
  assign A_BIST_DIN  = din_q;
  assign A_BIST_BM   = bm_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign FAIL        = fail_q;
  assign FAIL_ADDR   = fail_addr_q;
  assign FAIL_CNT    = fail_cnt_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural SRAM with injectable stuck-at bits and a
// scoreboard of the expected March C- operation stream.
module tb_sram_march_bist;

  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned N        = 1 << ADDR_W;
  localparam int unsigned BUSY_CYC = 10 * N + 1;
  localparam int unsigned OUT_W    = 4 + ADDR_W + 2 * DATA_W + 3 + ADDR_W + 8;
  localparam logic [DATA_W-1:0] ONES = '1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] dout;
  logic              en, men, wen, ren;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din, bm;
  logic              busy, done, fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [7:0]        fail_cnt;
  logic [OUT_W-1:0]  all_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } op_t;

  op_t exp_q[$];
  op_t obs_q[$];

  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] sa1 [N];
  logic [DATA_W-1:0] sa0 [N];

  sram_march_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .A_BIST_CLK (clk),
    .A_BIST_RST (rst),
    .START      (start),
    .A_DOUT     (dout),
    .A_BIST_EN  (en),
    .A_BIST_MEN (men),
    .A_BIST_WEN (wen),
    .A_BIST_REN (ren),
    .A_BIST_ADDR(addr),
    .A_BIST_DIN (din),
    .A_BIST_BM  (bm),
    .BUSY       (busy),
    .DONE       (done),
    .FAIL       (fail),
    .FAIL_ADDR  (fail_addr),
    .FAIL_CNT   (fail_cnt)
  );

  assign all_out = {en, men, wen, ren, addr, din, bm, busy, done, fail, fail_addr, fail_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, faults applied on the read path.
  always @(posedge clk) begin
    if (men && wen) mem[addr] <= (mem[addr] & ~bm) | (din & bm);
    if (men && ren) dout <= (mem[addr] | sa1[addr]) & ~sa0[addr];
  end

  function automatic op_t mk(input logic w, input int a, input logic [DATA_W-1:0] d);
    op_t o;
    o.w = w;
    o.a = ADDR_W'(a);
    o.d = d;
    return o;
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < int'(N); i++) begin
      sa1[i] = '0;
      sa0[i] = '0;
    end
  endtask

  task automatic push_march();
    for (int a = 0; a < int'(N); a++) exp_q.push_back(mk(1'b1, a, '0));
    for (int a = 0; a < int'(N); a++) begin
      exp_q.push_back(mk(1'b0, a, '0));
      exp_q.push_back(mk(1'b1, a, ONES));
    end
    for (int a = 0; a < int'(N); a++) begin
      exp_q.push_back(mk(1'b0, a, '0));
      exp_q.push_back(mk(1'b1, a, '0));
    end
    for (int a = int'(N) - 1; a >= 0; a--) begin
      exp_q.push_back(mk(1'b0, a, '0));
      exp_q.push_back(mk(1'b1, a, ONES));
    end
    for (int a = int'(N) - 1; a >= 0; a--) begin
      exp_q.push_back(mk(1'b0, a, '0));
      exp_q.push_back(mk(1'b1, a, '0));
    end
    for (int a = 0; a < int'(N); a++) exp_q.push_back(mk(1'b0, a, '0));
  endtask

  // Pulse START, then follow the run; optional START injection or reset abort at a cycle.
  task automatic run_march(input int inject_at, input int abort_at, output int busy_cnt);
    int  cyc;
    op_t o, e;
    bit  aborted;
    exp_q.delete();
    obs_q.delete();
    push_march();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    cyc = 0;
    aborted = 1'b0;
    n_checks++;
    if ({busy, done, fail, fail_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL start_state: busy/done/fail/cnt=%b/%b/%b/%0d required 1/0/0/0",
               busy, done, fail, fail_cnt);
    end
    while (busy === 1'b1 && cyc < 20000 && !aborted) begin
      busy_cnt++;
      if (men === 1'b1) begin
        o = '{w: wen, a: addr, d: din};
        obs_q.push_back(o);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_op: got w=%b addr=%h din=%h with no op expected", wen, addr, din);
        end else begin
          e = exp_q.pop_front();
          if ({o, ren, en, bm} !== {e, ~e.w, 1'b1, ONES}) begin
            n_fail++;
            $display("FAIL op_seq: got w=%b r=%b en=%b addr=%h din=%h bm=%h required w=%b addr=%h din=%h",
                     wen, ren, en, addr, din, bm, e.w, e.a, e.d);
          end
        end
      end
      if (cyc == abort_at) begin
        rst = 1'b1;
        #1;
        n_checks++;
        if (all_out !== '0) begin
          n_fail++;
          $display("FAIL abort_outputs: got %h required 0", all_out);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({en, men, wen, ren, busy} !== 5'b0) begin
          n_fail++;
          $display("FAIL abort_next_cycle: en/men/wen/ren/busy=%b required 00000",
                   {en, men, wen, ren, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
      end else begin
        start = (cyc == inject_at);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (cyc >= 20000) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: busy still high after %0d cycles", cyc);
    end
    if (!aborted) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL ops_missing: %0d ops not seen, required 0", exp_q.size());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    clear_faults();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h required 0", all_out);
    end
  endtask

  task automatic test_fault_free();
    int bc;
    clear_faults();
    run_march(-1, -1, bc);
    n_checks++;
    if ({bc, done, fail, fail_cnt} !== {32'(BUSY_CYC), 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL fault_free: busy=%0d done=%b fail=%b cnt=%0d required %0d/1/0/0",
               bc, done, fail, fail_cnt, BUSY_CYC);
    end
  endtask

  task automatic test_order();
    n_checks++;
    if (obs_q.size() != 10 * N) begin
      n_fail++;
      $display("FAIL op_count: got %0d required %0d", obs_q.size(), 10 * N);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (obs_q[i] !== mk(1'b1, i, '0)) begin
          n_fail++;
          $display("FAIL first_ops[%0d]: got w=%b addr=%h required w0 addr %h",
                   i, obs_q[i].w, obs_q[i].a, i);
        end
      end
      n_checks++;
      if (obs_q[5 * N] !== mk(1'b0, int'(N) - 1, '0)) begin
        n_fail++;
        $display("FAIL m3_first: got w=%b addr=%h required r addr %h",
                 obs_q[5 * N].w, obs_q[5 * N].a, N - 1);
      end
      n_checks++;
      if (obs_q[10 * N - 1] !== mk(1'b0, int'(N) - 1, '0)) begin
        n_fail++;
        $display("FAIL m5_last: got w=%b addr=%h required r addr %h",
                 obs_q[10 * N - 1].w, obs_q[10 * N - 1].a, N - 1);
      end
    end
  endtask

  task automatic test_stuck_at_1();
    int bc;
    clear_faults();
    sa1[9'h05A] = 16'h0008;
    run_march(-1, -1, bc);
    n_checks++;
    if ({done, fail, fail_addr, fail_cnt} !== {1'b1, 1'b1, 9'h05A, 8'd3}) begin
      n_fail++;
      $display("FAIL stuck_at_1: done=%b fail=%b addr=%h cnt=%0d required 1/1/05a/3",
               done, fail, fail_addr, fail_cnt);
    end
  endtask

  task automatic test_stuck_at_0();
    int bc;
    clear_faults();
    sa0[9'h000] = 16'h0001;
    sa0[9'h1FF] = 16'h0001;
    run_march(-1, -1, bc);
    n_checks++;
    if ({done, fail, fail_addr, fail_cnt} !== {1'b1, 1'b1, 9'h000, 8'd4}) begin
      n_fail++;
      $display("FAIL stuck_at_0: done=%b fail=%b addr=%h cnt=%0d required 1/1/000/4",
               done, fail, fail_addr, fail_cnt);
    end
  endtask

  // Bit 0 stuck high everywhere: 3N failing reads must saturate the counter.
  task automatic test_saturate();
    int bc;
    clear_faults();
    for (int i = 0; i < int'(N); i++) sa1[i] = 16'h0001;
    run_march(-1, -1, bc);
    n_checks++;
    if ({fail, fail_addr, fail_cnt} !== {1'b1, 9'h000, 8'd255}) begin
      n_fail++;
      $display("FAIL saturate: fail=%b addr=%h cnt=%0d required 1/000/255",
               fail, fail_addr, fail_cnt);
    end
    clear_faults();
  endtask

  task automatic test_reset_mid_run();
    int bc;
    clear_faults();
    run_march(-1, 2000, bc);
    repeat (3) @(negedge clk);
    n_checks++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL idle_after_abort: got %h required 0", all_out);
    end
    run_march(-1, -1, bc);
    n_checks++;
    if ({bc, done, fail} !== {32'(BUSY_CYC), 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rerun_after_abort: busy=%0d done=%b fail=%b required %0d/1/0",
               bc, done, fail, BUSY_CYC);
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    clear_faults();
    sa1[9'h05A] = 16'h0008;
    run_march(-1, -1, bc);
    repeat (20) @(negedge clk);
    n_checks++;
    if ({done, busy, en, fail} !== 4'b1001) begin
      n_fail++;
      $display("FAIL done_hold: done/busy/en/fail=%b required 1001", {done, busy, en, fail});
    end
    clear_faults();
    run_march(100, -1, bc);
    n_checks++;
    if ({bc, done, fail, fail_cnt} !== {32'(BUSY_CYC), 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL restart_ignore_start: busy=%0d done=%b fail=%b cnt=%0d required %0d/1/0/0",
               bc, done, fail, fail_cnt, BUSY_CYC);
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_order();
    test_stuck_at_1();
    test_stuck_at_0();
    test_saturate();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
